// File: rtl/strip_scan_sequencer_if.sv
// strip_scan_sequencer_if: configuration, pulser handshake and status bundle for the strip scan sequencer.
// Ports: none; slave modport is the sequencer (config/pulser/hit inputs, scan status outputs),
// master modport is the register interface plus pulser/decoder side that drives it.
interface strip_scan_sequencer_if;
    logic        start;
    logic        abort;
    logic [4:0]  first_strip;
    logic [4:0]  last_strip;
    logic [15:0] pulses_per_strip;
    logic [7:0]  settle_cycles;
    logic        pulser_ready;
    logic [31:0] halfstrips;
    logic [4:0]  strip_sel;
    logic [31:0] halfstrips_expect;
    logic        fire_pulse;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [15:0] pass_count;
    logic [15:0] err_count;
    logic        first_err_valid;
    logic [4:0]  first_err_strip;
    logic [31:0] first_err_hits;
    modport master (
        output start, abort, first_strip, last_strip, pulses_per_strip, settle_cycles, pulser_ready, halfstrips,
        input  strip_sel, halfstrips_expect, fire_pulse, busy, done, timeout, pass_count, err_count,
               first_err_valid, first_err_strip, first_err_hits
    );
    modport slave (
        input  start, abort, first_strip, last_strip, pulses_per_strip, settle_cycles, pulser_ready, halfstrips,
        output strip_sel, halfstrips_expect, fire_pulse, busy, done, timeout, pass_count, err_count,
               first_err_valid, first_err_strip, first_err_hits
    );
endinterface

// File: rtl/strip_scan_sequencer.sv
// strip_scan_sequencer: steps a half-strip range, fires the pulser per strip and checks sampled hits.
// Ports: clk (40 MHz), reset (async, active-high), bus (slave modport: start/abort/config in,
// pulser_ready/halfstrips in, strip_sel/halfstrips_expect/fire_pulse/busy/done/timeout/counts/first error out).
module strip_scan_sequencer #(
    parameter int SAMPLE_WIN  = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input logic                   clk,
    input logic                   reset,
    strip_scan_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETTLE, FIRE, WAIT_ACK, WAIT_DONE, SAMPLE, CHECK, FINISH} state_t;
    state_t      state_q, state_d;
    logic [4:0]  strip_q, strip_d, last_q, last_d, fe_strip_q, fe_strip_d;
    logic [7:0]  settle_q, settle_d;
    logic [15:0] cnt_q, cnt_d, ppc_q, ppc_d, pleft_q, pleft_d, pass_q, pass_d, err_q, err_d;
    logic [31:0] acc_q, acc_d, fe_hits_q, fe_hits_d, expect_w;
    logic        timeout_q, timeout_d, fe_valid_q, fe_valid_d;

    assign expect_w = 32'd1 << strip_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            strip_q    <= '0;
            last_q     <= '0;
            settle_q   <= '0;
            cnt_q      <= '0;
            ppc_q      <= '0;
            pleft_q    <= '0;
            pass_q     <= '0;
            err_q      <= '0;
            acc_q      <= '0;
            timeout_q  <= 1'b0;
            fe_valid_q <= 1'b0;
            fe_strip_q <= '0;
            fe_hits_q  <= '0;
        end else begin
            state_q    <= state_d;
            strip_q    <= strip_d;
            last_q     <= last_d;
            settle_q   <= settle_d;
            cnt_q      <= cnt_d;
            ppc_q      <= ppc_d;
            pleft_q    <= pleft_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            acc_q      <= acc_d;
            timeout_q  <= timeout_d;
            fe_valid_q <= fe_valid_d;
            fe_strip_q <= fe_strip_d;
            fe_hits_q  <= fe_hits_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        strip_d    = strip_q;
        last_d     = last_q;
        settle_d   = settle_q;
        cnt_d      = cnt_q;
        ppc_d      = ppc_q;
        pleft_d    = pleft_q;
        pass_d     = pass_q;
        err_d      = err_q;
        acc_d      = acc_q;
        timeout_d  = timeout_q;
        fe_valid_d = fe_valid_q;
        fe_strip_d = fe_strip_q;
        fe_hits_d  = fe_hits_q;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (bus.start && !bus.abort) begin
                    pass_d     = '0;
                    err_d      = '0;
                    timeout_d  = 1'b0;
                    fe_valid_d = 1'b0;
                    fe_strip_d = '0;
                    fe_hits_d  = '0;
                    last_d     = bus.last_strip;
                    settle_d   = bus.settle_cycles;
                    // ppc holds pulses-per-strip minus one; a request of 0 behaves as 1
                    ppc_d      = (bus.pulses_per_strip == 16'd0) ? 16'd0 : bus.pulses_per_strip - 16'd1;
                    pleft_d    = (bus.pulses_per_strip == 16'd0) ? 16'd0 : bus.pulses_per_strip - 16'd1;
                    strip_d    = bus.first_strip;
                    cnt_d      = {8'd0, bus.settle_cycles};
                    state_d    = (bus.first_strip > bus.last_strip) ? FINISH : SETTLE;
                end
                SETTLE: if (cnt_q == 16'd0) state_d = FIRE; else cnt_d = cnt_q - 16'd1;
                FIRE: begin
                    cnt_d   = 16'(ACK_TIMEOUT - 1);
                    state_d = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.pulser_ready) begin
                        state_d = WAIT_DONE;
                    end else if (cnt_q == 16'd0) begin
                        timeout_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                WAIT_DONE: if (bus.pulser_ready) begin
                    acc_d   = '0;
                    cnt_d   = 16'(SAMPLE_WIN - 1);
                    state_d = SAMPLE;
                end
                SAMPLE: begin
                    acc_d = acc_q | bus.halfstrips;
                    if (cnt_q == 16'd0) state_d = CHECK; else cnt_d = cnt_q - 16'd1;
                end
                CHECK: begin
                    if (acc_q == expect_w) begin
                        pass_d = pass_q + {15'd0, pass_q != 16'hFFFF};
                    end else begin
                        err_d = err_q + {15'd0, err_q != 16'hFFFF};
                        if (!fe_valid_q) begin
                            fe_valid_d = 1'b1;
                            fe_strip_d = strip_q;
                            fe_hits_d  = acc_q;
                        end
                    end
                    if (pleft_q != 16'd0) begin
                        pleft_d = pleft_q - 16'd1;
                        state_d = FIRE;
                    end else if (strip_q < last_q) begin
                        strip_d = strip_q + 5'd1;
                        pleft_d = ppc_q;
                        cnt_d   = {8'd0, settle_q};
                        state_d = SETTLE;
                    end else begin
                        state_d = FINISH;
                    end
                end
                FINISH: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.strip_sel         = strip_q;
    assign bus.halfstrips_expect = expect_w;
    assign bus.fire_pulse        = (state_q == FIRE);
    assign bus.busy              = (state_q != IDLE);
    assign bus.done              = (state_q == FINISH);
    assign bus.timeout           = timeout_q;
    assign bus.pass_count        = pass_q;
    assign bus.err_count         = err_q;
    assign bus.first_err_valid   = fe_valid_q;
    assign bus.first_err_strip   = fe_strip_q;
    assign bus.first_err_hits    = fe_hits_q;
endmodule

// File: tb/tb_strip_scan_sequencer.sv
// tb_strip_scan_sequencer: randomized and directed scans checked against a pulse-list scoreboard model.
// Ports: none; drives the sequencer through strip_scan_sequencer_if and emulates the pulser and decoders.
module tb_strip_scan_sequencer;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    strip_scan_sequencer_if bus();
    strip_scan_sequencer #(.SAMPLE_WIN(8), .ACK_TIMEOUT(255)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int tests = 0, fails = 0;
    int fires, dones, outstanding;
    int m_pass, m_err, m_fires;
    logic m_fev;
    logic [4:0] m_fes;
    logic [31:0] m_feh;
    int fq[$];
    bit exp_done;
    longint start_t, first_fire_t, last_fire_t, end_t;
    int ack_dly, busy_dly;
    bit never_ack, bad_en;
    logic [4:0] bad_strip;
    logic [31:0] bad_hits;

    // decoder emulation: every strip lights its own bit unless it is the faulted strip
    assign bus.halfstrips = (bad_en && bus.strip_sel == bad_strip) ? bad_hits : (32'd1 << bus.strip_sel);

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ceq(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk(act === exp, nm, act, exp);
    endtask

    // expected pulse list and result counts; only the first lim pulses reach their check
    task automatic model(input int f, input int l, input int p, input int lim);
        int n;
        logic [31:0] h;
        n = (p == 0) ? 1 : p;
        m_pass = 0; m_err = 0; m_fev = 1'b0; m_fes = '0; m_feh = '0; m_fires = 0;
        fq.delete();
        for (int st = f; st <= l; st++)
            for (int k = 0; k < n; k++) begin
                fq.push_back(st);
                m_fires++;
                if (m_fires <= lim) begin
                    h = (bad_en && 5'(st) == bad_strip) ? bad_hits : (32'd1 << st);
                    if (h == (32'd1 << st)) m_pass++;
                    else begin
                        m_err++;
                        if (!m_fev) begin m_fev = 1'b1; m_fes = 5'(st); m_feh = h; end
                    end
                end
            end
    endtask

    // pulser: acknowledges ack_dly cycles after a fire, stays busy for busy_dly cycles
    always begin
        @(negedge clk);
        if (bus.fire_pulse && !never_ack && !reset) begin
            repeat (ack_dly) @(negedge clk);
            bus.pulser_ready = 1'b0;
            repeat (busy_dly) @(negedge clk);
            bus.pulser_ready = 1'b1;
            outstanding = outstanding - 1;
        end
    end

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            ceq("expect_onehot", bus.halfstrips_expect, 32'd1 << bus.strip_sel);
            if (bus.fire_pulse) begin
                ceq("fire_handshake", 32'(outstanding), 32'd0);
                chk(fq.size() > 0, "fire_expected", 32'(fq.size()), 32'd1);
                if (fq.size() > 0) begin
                    ceq("fire_strip", 32'(bus.strip_sel), 32'(fq[0]));
                    void'(fq.pop_front());
                end
                if (fires == 0) ceq("first_fire_time", 32'($time), 32'(first_fire_t));
                last_fire_t = $time;
                fires++;
                outstanding++;
            end
            if (bus.done) begin
                dones++;
                ceq("done_allowed", 32'(bus.done), 32'(exp_done));
                ceq("done_pass", 32'(bus.pass_count), 32'(m_pass));
                ceq("done_err", 32'(bus.err_count), 32'(m_err));
                ceq("done_fev", 32'(bus.first_err_valid), 32'(m_fev));
                ceq("done_fes", 32'(bus.first_err_strip), 32'(m_fes));
                ceq("done_feh", bus.first_err_hits, m_feh);
                ceq("done_timeout", 32'(bus.timeout), 32'd0);
                ceq("done_busy", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic start_scan(input int f, input int l, input int p, input int s, input int lim, input bit expd);
        @(negedge clk);
        bus.first_strip = 5'(f);
        bus.last_strip = 5'(l);
        bus.pulses_per_strip = 16'(p);
        bus.settle_cycles = 8'(s);
        model(f, l, p, lim);
        exp_done = expd;
        fires = 0; dones = 0; outstanding = 0;
        bus.start = 1'b1;
        start_t = $time;
        first_fire_t = start_t + longint'((s + 2) * 10);
        @(negedge clk);
        bus.start = 1'b0;
        ceq("busy_after_start", 32'(bus.busy), 32'd1);
        ceq("strip_after_start", 32'(bus.strip_sel), 32'(f));
    endtask

    task automatic wait_end();
        int k = 0;
        while (bus.busy && k < 6000) begin @(negedge clk); k++; end
        end_t = $time;
        chk(k < 6000, "scan_end_bound", 32'(k), 32'd6000);
        #1;
    endtask

    task automatic run(input int f, input int l, input int p, input int s);
        start_scan(f, l, p, s, 1 << 30, 1'b1);
        wait_end();
        ceq("run_fires", 32'(fires), 32'(f <= l ? m_fires : 0));
        ceq("run_dones", 32'(dones), 32'd1);
        ceq("run_strip_end", 32'(bus.strip_sel), 32'(f <= l ? l : f));
        ceq("run_timeout", 32'(bus.timeout), 32'd0);
        ceq("run_pass", 32'(bus.pass_count), 32'(m_pass));
        ceq("run_err", 32'(bus.err_count), 32'(m_err));
    endtask

    task automatic check_reset_values(input string tag);
        ceq({tag, "_strip"}, 32'(bus.strip_sel), 32'd0);
        ceq({tag, "_expect"}, bus.halfstrips_expect, 32'd1);
        ceq({tag, "_ctl"}, {28'd0, bus.fire_pulse, bus.busy, bus.done, bus.timeout}, 32'd0);
        ceq({tag, "_counts"}, {bus.pass_count, bus.err_count}, 32'd0);
        ceq({tag, "_ferr"}, {26'd0, bus.first_err_valid, bus.first_err_strip}, 32'd0);
        ceq({tag, "_fhits"}, bus.first_err_hits, 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, f, l;
        reset = 1'b1;
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.first_strip = '0; bus.last_strip = '0; bus.pulses_per_strip = '0; bus.settle_cycles = '0;
        bus.pulser_ready = 1'b1;
        never_ack = 1'b0; bad_en = 1'b0; bad_strip = '0; bad_hits = '0;
        ack_dly = 2; busy_dly = 10;
        fires = 0; dones = 0; outstanding = 0;
        repeat (2) @(negedge clk);
        #1 check_reset_values("reset");
        @(negedge clk);
        reset = 1'b0;

        // clean scan 3..5, two pulses each
        run(3, 5, 2, 4);
        ceq("s1_fires", 32'(fires), 32'd6);
        ceq("s1_pass", 32'(bus.pass_count), 32'd6);
        ceq("s1_err", 32'(bus.err_count), 32'd0);

        // strip 4 returns 0x30
        bad_en = 1'b1; bad_strip = 5'd4; bad_hits = 32'h30;
        run(3, 5, 2, 4);
        bad_en = 1'b0;
        ceq("s2_err", 32'(bus.err_count), 32'd2);
        ceq("s2_pass", 32'(bus.pass_count), 32'd4);
        ceq("s2_fes", 32'(bus.first_err_strip), 32'd4);
        ceq("s2_feh", bus.first_err_hits, 32'h30);
        ceq("s2_fev", 32'(bus.first_err_valid), 32'd1);

        // pulser never acknowledges
        never_ack = 1'b1;
        start_scan(7, 8, 1, 0, 0, 1'b0);
        wait_end();
        never_ack = 1'b0;
        ceq("to_flag", 32'(bus.timeout), 32'd1);
        ceq("to_busy", 32'(bus.busy), 32'd0);
        ceq("to_dones", 32'(dones), 32'd0);
        ceq("to_fires", 32'(fires), 32'd1);
        ceq("to_cycles", 32'(end_t - last_fire_t), 32'd2560);

        // empty range finishes immediately; also clears the sticky timeout
        run(9, 2, 1, 3);
        ceq("empty_fires", 32'(fires), 32'd0);
        ceq("empty_latency", 32'(end_t - start_t), 32'd20);

        // abort during SAMPLE of the second strip, start in the same cycle
        ack_dly = 2; busy_dly = 5;
        start_scan(10, 12, 2, 1, 2, 1'b0);
        k = 0;
        while (fires < 3 && k < 2000) begin @(negedge clk); #1; k++; end
        while (bus.pulser_ready && k < 2000) begin @(negedge clk); #1; k++; end
        while (!bus.pulser_ready && k < 2000) begin @(negedge clk); #1; k++; end
        chk(k < 2000, "abort_wait_bound", 32'(k), 32'd2000);
        repeat (2) @(negedge clk);
        bus.abort = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.start = 1'b0;
        ceq("abort_busy", 32'(bus.busy), 32'd0);
        ceq("abort_strip", 32'(bus.strip_sel), 32'd11);
        ceq("abort_pass", 32'(bus.pass_count), 32'(m_pass));
        ceq("abort_err", 32'(bus.err_count), 32'(m_err));
        repeat (3) @(negedge clk);
        #1;
        ceq("abort_start_ignored", 32'(bus.busy), 32'd0);
        ceq("abort_no_done", 32'(dones), 32'd0);
        ceq("abort_fires", 32'(fires), 32'd3);
        ceq("abort_pass_held", 32'(bus.pass_count), 32'd2);

        // top of range with zero pulses requested
        run(30, 31, 0, 2);
        ceq("top_fires", 32'(fires), 32'd2);
        ceq("top_strip", 32'(bus.strip_sel), 32'd31);
        ceq("top_pass", 32'(bus.pass_count), 32'd2);

        // reset while waiting for pulser completion
        ack_dly = 1; busy_dly = 12;
        start_scan(0, 3, 1, 0, 1 << 30, 1'b0);
        k = 0;
        while (fires < 1 && k < 2000) begin @(negedge clk); #1; k++; end
        while (bus.pulser_ready && k < 2000) begin @(negedge clk); #1; k++; end
        chk(k < 2000, "reset_wait_bound", 32'(k), 32'd2000);
        @(negedge clk);
        reset = 1'b1;
        #1 check_reset_values("midreset");
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        while (!bus.pulser_ready && k < 100) begin @(negedge clk); #1; k++; end
        outstanding = 0;

        // randomized scans
        for (int r = 0; r < 10; r++) begin
            f = int'($urandom_range(0, 31));
            l = f + int'($urandom_range(0, 3));
            if (l > 31) l = 31;
            if ($urandom_range(0, 7) == 0 && f > 0) l = f - 1;
            ack_dly = int'($urandom_range(1, 3));
            busy_dly = int'($urandom_range(2, 8));
            bad_en = 1'($urandom_range(0, 1));
            bad_strip = 5'(f + int'($urandom_range(0, 3)));
            bad_hits = $urandom();
            run(f, l, int'($urandom_range(0, 3)), int'($urandom_range(0, 6)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/strip_scan_sequencer.md
# strip_scan_sequencer

Scan controller for the comparator test path on the 40 MHz domain. Steps a half-strip index across a programmed range, fires the pulser a programmed number of times per strip, and waits for the pulser handshake. After each pulse it accumulates the decoded `halfstrips` over a sample window and compares the result against a one-hot expected pattern. It sits between the serial register interface, which supplies configuration and reads status, and the comparator injector and triad decoders, replacing manual per-pulse `fire_pulse` writes with a hardware-sequenced scan.

## Interface
- `SAMPLE_WIN`, 8: number of cycles `halfstrips` is OR-accumulated after each pulse completes (1..255).
- `ACK_TIMEOUT`, 255: maximum cycles to wait for `pulser_ready` to fall after `fire_pulse`.
- `clk`  in  1  40 MHz system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a scan.
- `abort`  in  1  single-cycle request to stop the scan in progress.
- `first_strip`  in  5  first half-strip index of the scan.
- `last_strip`  in  5  last half-strip index of the scan (inclusive).
- `pulses_per_strip`  in  16  pulses fired per strip; 0 is treated as 1.
- `settle_cycles`  in  8  extra wait cycles after each strip change.
- `pulser_ready`  in  1  high when the pulser is idle; falls to acknowledge a fire and rises on completion.
- `halfstrips`  in  32  decoded half-strip hits.
- `strip_sel`  out  5  current half-strip index.
- `halfstrips_expect`  out  32  one-hot pattern `1 << strip_sel`.
- `fire_pulse`  out  1  single-cycle pulse request.
- `busy`  out  1  high while a scan is in progress.
- `done`  out  1  single-cycle pulse on normal completion.
- `timeout`  out  1  sticky flag: ack timeout occurred; cleared on next accepted start.
- `pass_count`  out  16  number of matching pulses, saturating.
- `err_count`  out  16  number of mismatching pulses, saturating.
- `first_err_valid`  out  1  high once the first mismatch has been captured.
- `first_err_strip`  out  5  strip index of the first mismatch.
- `first_err_hits`  out  32  accumulated hits of the first mismatch.

## Operation
- Reset values: all outputs 0; `halfstrips_expect` = 0x00000001, following `strip_sel` = 0. State is IDLE.
- States: IDLE, SETTLE, FIRE, WAIT_ACK, WAIT_DONE, SAMPLE, CHECK, FINISH.
- **IDLE**
  - `start` is accepted only in IDLE.
  - On accept: clear the counts, `timeout`, and the first_err fields; latch the config inputs; load `strip_sel` <= `first_strip`; go to SETTLE.
  - If `first_strip` > `last_strip`, go directly to FINISH with no pulse fired.
- **SETTLE** lasts `settle_cycles`+1 cycles, then goes to FIRE.
- **FIRE** drives `fire_pulse` = 1 for exactly 1 cycle, loads the timeout counter, then goes to WAIT_ACK.
- **WAIT_ACK**
  - `pulser_ready` = 0 -> WAIT_DONE.
  - If `ACK_TIMEOUT` cycles pass without it: set `timeout`, go to IDLE, and do not pulse `done`.
- **WAIT_DONE**
  - `pulser_ready` = 1 -> SAMPLE.
  - No timeout applies in this state.
- **SAMPLE** clears the accumulator on entry, ORs in `halfstrips` for `SAMPLE_WIN` cycles, then goes to CHECK.
- **CHECK** (1 cycle) compares the accumulator to `halfstrips_expect`:
  - Equal: increment `pass_count`.
  - Not equal: increment `err_count`; if `first_err_valid` = 0, capture `first_err_strip`/`first_err_hits` and set `first_err_valid`.
  - Next state, in priority order:
    - pulses remaining for this strip -> FIRE, with no re-settle;
    - `strip_sel` < last -> increment `strip_sel`, go to SETTLE;
    - otherwise -> FINISH.
- **FINISH** pulses `done` for 1 cycle, then goes to IDLE.
- **abort** in any non-IDLE state: go to IDLE on the next edge, no `done`; counts and `strip_sel` are held for readback.
- `abort` wins over `start` when both arrive in the same cycle.
- `busy` = 1 in every state except IDLE.
- Counters saturate at 0xFFFF with no wrap; the per-strip pulse counter is 16-bit.
- `last_strip` = 31 terminates without wrapping `strip_sel` to 0.
- `reset` asserted mid-scan returns all outputs to their reset values immediately (asynchronously).

## Timing
- `start` sampled at edge 0: `busy` and the new `strip_sel` are visible after edge 0.
- With `settle_cycles` = s, `fire_pulse` is high in cycle s+2 after start.
- `fire_pulse` never asserts twice without an intervening pulser_ready 1->0->1 sequence.
- Per-pulse cost with immediate ack (a cycles) and pulser busy time (b cycles): 1 + a + b + `SAMPLE_WIN` + 1 cycles.
- `halfstrips_expect` changes only on the edge that changes `strip_sel`, which is at least `settle_cycles`+1 cycles before the next fire.
- The count updates made in CHECK are visible in the same cycle that `done` is asserted.

## Test plan
- Strips 3..5, 2 pulses each, s = 4, pulser model ack 2 / busy 10 cycles, hits = expect -> 6 `fire_pulse`, `pass_count` = 6, `err_count` = 0, a single `done`.
- Same run with the model forcing strip 4 to return 0x00000030 -> `err_count` = 2, `pass_count` = 4, `first_err_strip` = 4, `first_err_hits` = 0x00000030.
- Pulser never drops `pulser_ready` -> `timeout` = 1 after 255 cycles, `busy` = 0, no `done`, exactly 1 `fire_pulse`.
- `first_strip` = 9, `last_strip` = 2 -> `done` within 2 cycles of start, 0 fires, counts 0.
- `abort` during SAMPLE of the 2nd strip, then a second `start` in the same cycle as `abort` -> IDLE, no `done`, counts held; the second `start` is ignored.
- Range 30..31 with `pulses_per_strip` = 0 -> exactly 1 pulse per strip, `strip_sel` ends at 31 (no wrap).
- `reset` asserted mid-WAIT_DONE -> all outputs at reset values before the next edge.
